mem_stage_access_unit: RTL

- MEM-stage access sequencer, directly downstream of the EX/MEM pipeline register.
- Takes the registered memory request (read/write/atomic, address, store data) and drives the single-request dcache handshake until dhit.
- Owns the per-core LL/SC link register and invalidates it on coherence snoops.
- Returns load or SC-result data plus stall/valid to the hazard unit and the MEM/WB register.

---
 rtl/mem_stage_access_unit.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/mem_stage_access_unit.sv
// MEM-stage dcache access sequencer with a per-core LL/SC link register.
// Define LLSC_ATOMIC_EN to build LL/SC semantics; otherwise LL acts as LW and SC as SW.
module mem_stage_access_unit #(
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int OFS = 2
) (
  input  logic          CLK,
  input  logic          nRST,
  input  logic          ex_ren,
  input  logic          ex_wen,
  input  logic          ex_atomic,
  input  logic [AW-1:0] ex_addr,
  input  logic [DW-1:0] ex_store,
  input  logic          mem_ack,
  input  logic          dhit,
  input  logic [DW-1:0] dload,
  input  logic          ccinv,
  input  logic [AW-1:0] ccsnoopaddr,
  output logic          dREN,
  output logic          dWEN,
  output logic [AW-1:0] daddr,
  output logic [DW-1:0] dstore,
  output logic          mem_stall,
  output logic          mem_valid,
  output logic [DW-1:0] mem_rdata,
  output logic          link_valid
);
  typedef enum logic [1:0] {IDLE, REQ, SCFAIL, DONE} state_t;
  localparam logic [DW-1:0] SC_OK = {{(DW-1){1'b0}}, 1'b1};

  // Handshake: dREN/dWEN rise one cycle after the request is seen in IDLE and
  // stay stable until the cycle dhit is high; mem_valid holds until mem_ack.
  state_t            state;
  logic              op_rd;
  logic              op_ll;
  logic              op_sc;
  logic              link_v;
  logic [AW-OFS-1:0] link_word;

  logic req_any;
  logic req_rd;
  logic req_ll;
  logic req_sc;
  logic snoop_hit;
  logic snoop_new;
  logic link_miss;

  assign req_any = ex_ren | ex_wen;
  assign req_rd  = ex_ren & ~ex_wen;

`ifdef LLSC_ATOMIC_EN
  logic unused_snoop_ofs;
  assign req_ll     = req_rd & ex_atomic;
  assign req_sc     = ex_wen & ex_atomic;
  assign snoop_hit  = ccinv & link_v & (ccsnoopaddr[AW-1:OFS] == link_word);
  assign snoop_new  = ccinv & (ccsnoopaddr[AW-1:OFS] == daddr[AW-1:OFS]);
  assign link_miss  = ~link_v | (ex_addr[AW-1:OFS] != link_word);
  assign link_valid = link_v;
  assign unused_snoop_ofs = ^ccsnoopaddr[OFS-1:0];
`else
  logic unused_llsc;
  assign req_ll     = 1'b0;
  assign req_sc     = 1'b0;
  assign snoop_hit  = 1'b0;
  assign snoop_new  = 1'b0;
  assign link_miss  = 1'b0;
  assign link_valid = 1'b0;
  assign unused_llsc = ^{ex_atomic, ccinv, ccsnoopaddr, link_v};
`endif

  // Gated by nRST so a reset mid-access releases the pipeline immediately.
  assign mem_stall = nRST & (((state == IDLE) & req_any) | (state == REQ) | (state == SCFAIL));

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= IDLE;
      op_rd     <= 1'b0;
      op_ll     <= 1'b0;
      op_sc     <= 1'b0;
      link_v    <= 1'b0;
      link_word <= '0;
      dREN      <= 1'b0;
      dWEN      <= 1'b0;
      daddr     <= '0;
      dstore    <= '0;
      mem_valid <= 1'b0;
      mem_rdata <= '0;
    end else begin
      if (snoop_hit) link_v <= 1'b0;
      case (state)
        IDLE: begin
          if (req_any) begin
            daddr  <= ex_addr;
            dstore <= ex_store;
            op_rd  <= req_rd;
            op_ll  <= req_ll;
            op_sc  <= req_sc;
            if (req_sc && link_miss) begin
              mem_rdata <= '0;
              state     <= SCFAIL;
            end else begin
              dREN  <= req_rd;
              dWEN  <= ex_wen;
              state <= REQ;
            end
          end
        end
        REQ: begin
          if (dhit) begin
            dREN      <= 1'b0;
            dWEN      <= 1'b0;
            mem_valid <= 1'b1;
            mem_rdata <= op_rd ? dload : SC_OK;
            state     <= DONE;
            // A snoop to the same word in the LL completion cycle wins over the set.
            if (op_ll) begin
              link_v    <= ~snoop_new;
              link_word <= daddr[AW-1:OFS];
            end else if (op_sc) begin
              link_v <= 1'b0;
            end else if (!op_rd && (daddr[AW-1:OFS] == link_word)) begin
              link_v <= 1'b0;
            end
          end else if (op_sc && snoop_hit) begin
            dWEN      <= 1'b0;
            mem_rdata <= '0;
            state     <= SCFAIL;
          end
        end
        SCFAIL: begin
          link_v    <= 1'b0;
          mem_rdata <= '0;
          mem_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (mem_ack) begin
            mem_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
